// File: rtl/control_unit.sv
// control_unit
// Multi-cycle controller for the processor datapath. Each instruction walks
// FETCH -> EXEC -> WB (3 cycles). INPUT/OUTPUT pause in WAIT_IO until a
// debounced press of the board button. HALT parks the FSM until reset.
//
// Optional feature macro: CTRL_CONFIRM_SYNC_EN
//   defined   : confirm goes through a 2-flop synchronizer (+2 cycles latency)
//   undefined : confirm is sampled directly (must be synchronous to clock)
//
// Ports
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   opcode[5:0]      : instruction opcode from datapath (latched in FETCH)
//   flagJB           : branch-taken flag, only looked at in WB
//   confirm          : user push-button level
//   flagDM           : data memory write
//   flagJR           : jump-register address select
//   flagLSR          : register-indirect data address
//   flagRF           : register-file write
//   flagPC[1:0]      : 0 hold, 1 increment, 2 load
//   flagBQ[1:0]      : 0 none, 1 BEQ, 2 BNE
//   flagMuxRF[2:0]   : 0 zero, 1 ALU, 2 DM, 3 IN, 4 imm
//   waiting, halted  : state indicators
//   state[2:0]       : debug state code
module control_unit #(
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       flagJB,
  input  logic       confirm,
  output logic       flagDM,
  output logic       flagJR,
  output logic       flagLSR,
  output logic       flagRF,
  output logic [1:0] flagPC,
  output logic [1:0] flagBQ,
  output logic [2:0] flagMuxRF,
  output logic       waiting,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    EXEC    = 3'd1,
    WB      = 3'd2,
    WAIT_IO = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [5:0] OP_ALU    = 6'd0;
  localparam logic [5:0] OP_ALUI   = 6'd1;
  localparam logic [5:0] OP_LOADI  = 6'd2;
  localparam logic [5:0] OP_LOAD   = 6'd3;
  localparam logic [5:0] OP_LOADR  = 6'd4;
  localparam logic [5:0] OP_STORE  = 6'd5;
  localparam logic [5:0] OP_STORER = 6'd6;
  localparam logic [5:0] OP_JUMP   = 6'd7;
  localparam logic [5:0] OP_JR     = 6'd8;
  localparam logic [5:0] OP_BEQ    = 6'd9;
  localparam logic [5:0] OP_BNE    = 6'd10;
  localparam logic [5:0] OP_INPUT  = 6'd11;
  localparam logic [5:0] OP_OUTPUT = 6'd12;
  localparam logic [5:0] OP_NOP    = 6'd13;
  localparam logic [5:0] OP_HALT   = 6'd63;

  // Counter only needs to reach DEBOUNCE_LEN-1; the final high sample accepts.
  localparam int CNT_W = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LEN - 1);

  state_t           stateCur_r;
  state_t           stateNxt_s;
  logic [5:0]       op_r;
  logic             armed_r;
  logic [CNT_W-1:0] debCnt_r;
  logic             confirmSample_s;
  logic             isIo_s;
  logic             accept_s;

`ifdef CTRL_CONFIRM_SYNC_EN
  logic [1:0] confirmSync_r;

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge clock) begin
    if (reset) begin
      confirmSync_r <= 2'b00;
    end else begin
      confirmSync_r <= {confirmSync_r[0], confirm};
    end
  end

  assign confirmSample_s = confirmSync_r[1];
`else
  assign confirmSample_s = confirm;
`endif

  assign isIo_s   = (op_r == OP_INPUT) || (op_r == OP_OUTPUT);
  // Press accepted on the DEBOUNCE_LEN-th consecutive armed high sample.
  assign accept_s = (stateCur_r == WAIT_IO) && armed_r && confirmSample_s
                    && (debCnt_r == CNT_LAST);

  // Next-state logic.
  always_comb begin
    stateNxt_s = stateCur_r;
    case (stateCur_r)
      FETCH:   stateNxt_s = EXEC;
      EXEC: begin
        if (isIo_s) begin
          stateNxt_s = WAIT_IO;
        end else if (op_r == OP_HALT) begin
          stateNxt_s = HALT;
        end else begin
          stateNxt_s = WB;
        end
      end
      WB:      stateNxt_s = FETCH;
      WAIT_IO: begin
        if (accept_s) begin
          stateNxt_s = WB;
        end else begin
          stateNxt_s = WAIT_IO;
        end
      end
      HALT:    stateNxt_s = HALT;
      default: stateNxt_s = FETCH;
    endcase
  end

  // State, opcode latch and debounce registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateCur_r <= FETCH;
      op_r       <= OP_NOP;
      armed_r    <= 1'b0;
      debCnt_r   <= '0;
    end else begin
      stateCur_r <= stateNxt_s;
      if (stateCur_r == FETCH) begin
        op_r <= opcode;
      end else begin
        op_r <= op_r;
      end
      // A button already held when the wait starts must be released first.
      if ((stateCur_r == EXEC) && (stateNxt_s == WAIT_IO)) begin
        armed_r <= ~confirmSample_s;
      end else if ((stateCur_r == WAIT_IO) && !confirmSample_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
      // Outside WAIT_IO, on a low sample, or on acceptance the count restarts.
      if ((stateCur_r == WAIT_IO) && armed_r && confirmSample_s && !accept_s) begin
        debCnt_r <= debCnt_r + CNT_W'(1);
      end else begin
        debCnt_r <= '0;
      end
    end
  end

  // Control flags decoded from registered state and latched opcode.
  always_comb begin
    flagDM    = 1'b0;
    flagJR    = 1'b0;
    flagLSR   = 1'b0;
    flagRF    = 1'b0;
    flagPC    = 2'd0;
    flagBQ    = 2'd0;
    flagMuxRF = 3'd0;
    case (stateCur_r)
      EXEC, WB: begin
        case (op_r)
          OP_ALU, OP_ALUI: flagMuxRF = 3'd1;
          OP_LOADI:        flagMuxRF = 3'd4;
          OP_LOAD:         flagMuxRF = 3'd2;
          OP_LOADR: begin
            flagMuxRF = 3'd2;
            flagLSR   = 1'b1;
          end
          OP_STORER:       flagLSR = (stateCur_r == EXEC);
          OP_JR:           flagJR = 1'b1;
          OP_BEQ:          flagBQ = 2'd1;
          OP_BNE:          flagBQ = 2'd2;
          OP_INPUT:        flagMuxRF = 3'd3;
          default:         flagMuxRF = 3'd0;
        endcase
        if (stateCur_r == EXEC) begin
          flagDM = (op_r == OP_STORE) || (op_r == OP_STORER);
        end else begin
          flagRF = (op_r <= OP_LOADR) || (op_r == OP_INPUT);
          if ((op_r == OP_JUMP) || (op_r == OP_JR)) begin
            flagPC = 2'd2;
          end else if (((op_r == OP_BEQ) || (op_r == OP_BNE)) && flagJB) begin
            flagPC = 2'd2;
          end else begin
            flagPC = 2'd1;
          end
        end
      end
      WAIT_IO: begin
        if (op_r == OP_INPUT) begin
          flagMuxRF = 3'd3;
        end else begin
          flagMuxRF = 3'd0;
        end
      end
      default: flagMuxRF = 3'd0;
    endcase
  end

  assign waiting = (stateCur_r == WAIT_IO);
  assign halted  = (stateCur_r == HALT);
  assign state   = stateCur_r;

endmodule
